// File: rtl/bram_port_arbiter.sv
// N-channel request/grant arbiter sharing one synchronous BRAM port, with per-channel read-return strobes.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority (lowest requesting index wins).
module bram_port_arbiter #(
   parameter int N_CH   = 2,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9,
   parameter int RD_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_CH-1:0]        req,
   input  logic [N_CH-1:0]        we,
   input  logic [N_CH*ADDR_W-1:0] addr,
   input  logic [N_CH*DATA_W-1:0] wdata,
   output logic [N_CH-1:0]        gnt,
   output logic [N_CH-1:0]        rvalid,
   output logic [DATA_W-1:0]      rdata,
   output logic                   mem_en,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_din,
   input  logic [DATA_W-1:0]      mem_dout
);
   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic              win_valid;
   logic [IDX_W-1:0]  win_idx;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              accept;

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch is inferred.
      win_valid = 1'b0;
      win_idx   = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_valid = 1'b1;
            win_idx   = IDX_W'(i);
         end
      end
   end
`else
   logic [IDX_W-1:0] last;

   // Scan from lowest to highest priority; the final hit (nearest last+1) wins.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int k = N_CH; k >= 1; k--) begin
         for (int i = 0; i < N_CH; i++) begin
            if (req[i] && (i == (int'(last) + k) % N_CH)) begin
               win_valid = 1'b1;
               win_idx   = IDX_W'(i);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= IDX_W'(N_CH - 1);
      end else if (accept) begin
         last <= win_idx;
      end
   end
`endif

   // Grant is suppressed while in reset so requests held during reset are ignored.
   always_comb begin
      gnt       = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_CH; i++) begin
         gnt[i] = rst_n && win_valid && (win_idx == IDX_W'(i));
         if (gnt[i]) begin
            sel_we    = we[i];
            sel_addr  = addr[i*ADDR_W +: ADDR_W];
            sel_wdata = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign accept = |gnt;
   assign rdata  = mem_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
      end else if (accept) begin
         mem_en   <= 1'b1;
         mem_we   <= sel_we;
         mem_addr <= sel_addr;
         mem_din  <= sel_wdata;
      end else begin
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
      end
   end

   logic             tag_vld [RD_LAT];
   logic [IDX_W-1:0] tag_ch  [RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this small tag array is reset, unlike a data RAM, because a stale valid bit would fire rvalid.
         for (int s = 0; s < RD_LAT; s++) begin
            tag_vld[s] <= 1'b0;
            tag_ch[s]  <= '0;
         end
         rvalid <= '0;
      end else begin
         tag_vld[0] <= accept && !sel_we;
         tag_ch[0]  <= win_idx;
         for (int s = 1; s < RD_LAT; s++) begin
            tag_vld[s] <= tag_vld[s-1];
            tag_ch[s]  <= tag_ch[s-1];
         end
         for (int i = 0; i < N_CH; i++) begin
            rvalid[i] <= tag_vld[RD_LAT-1] && (tag_ch[RD_LAT-1] == IDX_W'(i));
         end
      end
   end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: behavioural arbitration/BRAM model checked every cycle,
// plus directed literal checks; a second instance covers N_CH=3, RD_LAT=2.
module tb_bram_port_arbiter;
   localparam int N   = 2;
   localparam int DW  = 16;
   localparam int AW  = 9;
   localparam int LAT = 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N-1:0]    req, we, gnt, rvalid;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [DW-1:0]   rdata, mem_din, mem_dout;
   logic            mem_en, mem_we;
   logic [AW-1:0]   mem_addr;

   bram_port_arbiter #(.N_CH(N), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout));

   logic [2:0]    req3, we3, gnt3, rvalid3;
   logic [3*AW-1:0] addr3;
   logic [3*DW-1:0] wdata3;
   logic [DW-1:0] rdata3, mem_din3, mem_dout3, d1_3;
   logic          mem_en3, mem_we3;
   logic [AW-1:0] mem_addr3;

   bram_port_arbiter #(.N_CH(3), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
      .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3),
      .mem_addr(mem_addr3), .mem_din(mem_din3), .mem_dout(mem_dout3));

   function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
      return (a == 9'h00A) ? 16'h1234 : {a[7:0], ~a[7:0]};
   endfunction

   // Write-first BRAMs; unwritten words read as init_val.
   logic [DW-1:0] bram  [int];
   logic [DW-1:0] bram3 [int];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            bram[int'(mem_addr)] = mem_din;
            mem_dout <= mem_din;
         end else begin
            mem_dout <= bram.exists(int'(mem_addr)) ? bram[int'(mem_addr)] : init_val(mem_addr);
         end
      end
   end
   always @(posedge clk) begin
      if (mem_en3) begin
         if (mem_we3) begin
            bram3[int'(mem_addr3)] = mem_din3;
            d1_3 <= mem_din3;
         end else begin
            d1_3 <= bram3.exists(int'(mem_addr3)) ? bram3[int'(mem_addr3)] : init_val(mem_addr3);
         end
      end
      mem_dout3 <= d1_3;
   end

   int n_chk = 0;
   int n_bad = 0;
   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Requester driver: per-channel transaction queues, popped on an accepted edge.
   typedef struct packed {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } txn_t;
   txn_t q0[$];
   txn_t q1[$];
   logic [N-1:0] gnt_s = '0;

   task automatic push(int ch, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
      txn_t t;
      t = '{w: w, a: a, d: d};
      if (ch == 0) q0.push_back(t);
      else         q1.push_back(t);
   endtask

   task automatic drive_inputs();
      req = '0;
      we  = '0;
      if (q0.size() > 0) begin
         req[0] = 1'b1; we[0] = q0[0].w; addr[0 +: AW] = q0[0].a; wdata[0 +: DW] = q0[0].d;
      end
      if (q1.size() > 0) begin
         req[1] = 1'b1; we[1] = q1[0].w; addr[AW +: AW] = q1[0].a; wdata[DW +: DW] = q1[0].d;
      end
   endtask

   always @(negedge clk) gnt_s <= gnt;
   always @(posedge clk) begin
      if (rst_n) begin
         if (gnt_s[0] && req[0]) void'(q0.pop_front());
         if (gnt_s[1] && req[1]) void'(q1.pop_front());
      end
      #1;
      drive_inputs();
   end

   // Behavioural model: arbitration order, port registers, memory image and pending read returns.
   typedef struct {
      int            due;
      int            ch;
      logic [DW-1:0] d;
   } rd_t;
   rd_t           pend[$];
   logic [DW-1:0] m_mem [int];
   int            m_last  = N - 1;
   int            cyc     = 0;
   logic          exp_en  = 1'b0;
   logic          exp_we  = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_din  = '0;

   function automatic int m_winner();
`ifdef ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (req[i]) return i;
`else
      for (int k = 1; k <= N; k++) if (req[(m_last + k) % N]) return (m_last + k) % N;
`endif
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_last = N - 1; cyc = 0; pend.delete();
         exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
      end else begin
         int w;
         logic [AW-1:0] a;
         w = m_winner();
         cyc++;
         if (w >= 0) begin
            a        = addr[w*AW +: AW];
            exp_en   = 1'b1;
            exp_we   = we[w];
            exp_addr = a;
            exp_din  = wdata[w*DW +: DW];
            if (we[w]) m_mem[int'(a)] = wdata[w*DW +: DW];
            else pend.push_back('{due: cyc + LAT, ch: w,
                                  d: m_mem.exists(int'(a)) ? m_mem[int'(a)] : init_val(a)});
            m_last = w;
         end else begin
            exp_en = 1'b0;
            exp_we = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      int            w;
      logic [N-1:0]  exp_g, exp_rv;
      logic [DW-1:0] exp_rd;
      w      = m_winner();
      exp_g  = (rst_n && w >= 0) ? (N'(1) << w) : '0;
      exp_rv = '0;
      exp_rd = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         exp_rv = N'(1) << pend[0].ch;
         exp_rd = pend[0].d;
         void'(pend.pop_front());
      end
      check("m_gnt", gnt, exp_g);
      check("m_mem_en", mem_en, exp_en);
      check("m_mem_we", mem_we, exp_we);
      check("m_mem_addr", mem_addr, exp_addr);
      check("m_mem_din", mem_din, exp_din);
      check("m_rvalid", rvalid, exp_rv);
      if (exp_rv != '0) check("m_rdata", rdata, exp_rd);
   end

   task automatic wait_idle(int max_cyc);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || pend.size() > 0) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check("drain_in_time", 64'(n < max_cyc), 64'd1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [N-1:0]  exp_g, exp_rv, seen_rv;
      logic [DW-1:0] exp_rd, seen_rd;
      int            n;
      req = '0; we = '0; addr = '0; wdata = '0;
      req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Reset with both channels requesting
      push(0, 1'b0, 9'd3, '0);
      push(1, 1'b0, 9'd4, '0);
      repeat (3) @(negedge clk);
      check("rst_gnt", gnt, 2'b00);
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_rvalid", rvalid, 2'b00);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("first_gnt", gnt, 2'b01);
      wait_idle(20);

      // Single read on ch1
      push(1, 1'b0, 9'h00A, '0);
      @(negedge clk); check("rd_gnt", gnt, 2'b10);
      @(negedge clk); check("rd_mem_en", mem_en, 1'b1); check("rd_mem_addr", mem_addr, 9'h00A);
      @(negedge clk); check("rd_rvalid", rvalid, 2'b10); check("rd_rdata", rdata, 16'h1234);
      wait_idle(20);

      // Contention: continuous reads, ch0 addr 1, ch1 addr 2
      for (int i = 0; i < 6; i++) begin
         push(0, 1'b0, 9'd1, '0);
         push(1, 1'b0, 9'd2, '0);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
`ifdef ARB_FIXED_PRIO_EN
         exp_g = 2'b01;
         exp_rv = 2'b01; exp_rd = 16'h01FE;
`else
         exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
         exp_rv = (i % 2 == 1) ? 2'b10 : 2'b01;
         exp_rd = (i % 2 == 1) ? 16'h02FD : 16'h01FE;
`endif
         if (i < 4) check("cont_gnt", gnt, exp_g);
         if (i >= 2) begin
            check("cont_rvalid", rvalid, exp_rv);
            check("cont_rdata", rdata, exp_rd);
         end
      end
      wait_idle(60);

      // Write then read of the same address from another channel
      push(0, 1'b1, 9'h01F, 16'hBEEF);
      push(1, 1'b0, 9'h01F, '0);
      seen_rv = '0; seen_rd = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rvalid != '0 && seen_rv == '0) begin seen_rv = rvalid; seen_rd = rdata; end
      end
      check("wr_rd_rvalid", seen_rv, 2'b10);
      check("wr_rd_rdata", seen_rd, 16'hBEEF);
      wait_idle(20);

      // Three channels, RD_LAT=2, consecutive reads
      @(posedge clk); #1 req3 = 3'b111; addr3 = {9'd6, 9'd5, 9'd4};
      @(negedge clk); check("l3_gnt0", gnt3, 3'b001);
      @(posedge clk); #1 req3 = 3'b110;
      @(negedge clk); check("l3_gnt1", gnt3, 3'b010);
      check("l3_en0", mem_en3, 1'b1); check("l3_addr0", mem_addr3, 9'd4);
      @(posedge clk); #1 req3 = 3'b100;
      @(negedge clk); check("l3_gnt2", gnt3, 3'b100); check("l3_addr1", mem_addr3, 9'd5);
      @(posedge clk); #1 req3 = 3'b000;
      @(negedge clk); check("l3_addr2", mem_addr3, 9'd6);
      check("l3_rv0", rvalid3, 3'b001); check("l3_rd0", rdata3, 16'h04FB);
      @(negedge clk); check("l3_rv1", rvalid3, 3'b010); check("l3_rd1", rdata3, 16'h05FA);
      @(negedge clk); check("l3_rv2", rvalid3, 3'b100); check("l3_rd2", rdata3, 16'h06F9);
      @(negedge clk); check("l3_rv_end", rvalid3, 3'b000);

      // Reset in the cycle after a read's mem_en cycle
      push(0, 1'b0, 9'd7, '0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (mem_en !== 1'b1 && n < 8);
      check("mid_en_seen", mem_en, 1'b1);
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      check("mid_rvalid", rvalid, 2'b00);
      check("mid_mem_en", mem_en, 1'b0);
      check("mid_mem_addr", mem_addr, 9'd0);
      @(negedge clk);
      push(0, 1'b0, 9'd8, '0);
      push(1, 1'b0, 9'd9, '0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk); check("restart_gnt", gnt, 2'b01);
      wait_idle(20);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
